// File: rtl/cordic_apb_sequencer_if.sv
// Bundles the job port, the result stream and the APB master bus of the CORDIC sequencer.
// valid/ready: a beat transfers on a rising edge where valid&ready are both 1; valid holds its payload until then.
interface cordic_apb_sequencer_if;
  logic        job_valid;
  logic        job_ready;
  logic [5:0]  job_cmd;
  logic [4:0]  job_xyfrac;
  logic [4:0]  job_phfrac;
  logic [31:0] job_a;
  logic [31:0] job_b;
  logic [31:0] job_c;
  logic [31:0] job_d;
  logic [2:0]  job_nout;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_data;
  logic [2:0]  res_idx;
  logic        res_last;
  logic        res_err;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [5:0]  PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        INT;

  modport master (
    input  job_valid, job_cmd, job_xyfrac, job_phfrac, job_a, job_b, job_c, job_d, job_nout,
    input  res_ready, PRDATA, INT,
    output job_ready, res_valid, res_data, res_idx, res_last, res_err,
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA
  );

  modport slave (
    output job_valid, job_cmd, job_xyfrac, job_phfrac, job_a, job_b, job_c, job_d, job_nout,
    output res_ready, PRDATA, INT,
    input  job_ready, res_valid, res_data, res_idx, res_last, res_err,
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA
  );
endinterface

// File: rtl/cordic_apb_sequencer.sv
// APB master that programs the CORDIC peripheral for one job, waits for INT, streams the OUTn
// registers out as result beats and finally clears the peripheral's CONTROL register.
module cordic_apb_sequencer #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                          PCLK,
  input  logic                          PRESETn,
  cordic_apb_sequencer_if.master        bus,
  output logic [2:0]                    dbg_state_o
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WR       = 3'd1,
    S_WAIT_INT = 3'd2,
    S_RD       = 3'd3,
    S_RES      = 3'd4,
    S_CLR      = 3'd5
  } state_e;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_e      state_q, state_d;
  logic        phase_q, phase_d;
  logic [2:0]  widx_q, widx_d;
  logic [2:0]  ridx_q, ridx_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        job_ready_q, job_ready_d;
  logic        res_valid_q, res_valid_d;
  logic [31:0] res_data_q, res_data_d;
  logic [2:0]  res_idx_q, res_idx_d;
  logic        res_last_q, res_last_d;
  logic        res_err_q, res_err_d;
  logic [5:0]  cmd_q;
  logic [4:0]  xy_q, ph_q;
  logic [31:0] a_q, b_q, c_q, d_q;
  logic [2:0]  nout_q;
  logic        accept;
  logic        psel, penable, pwrite;
  logic [5:0]  paddr, wr_addr, rd_addr;
  logic [31:0] pwdata, wr_data;

  // Write index 0..6 walks the programming sequence; index 6 is the CONTROL start write.
  always_comb begin
    wr_addr = 6'h00;
    wr_data = 32'h0;
    case (widx_q)
      3'd0:    begin wr_addr = 6'h2C; wr_data = {27'd0, xy_q};  end
      3'd1:    begin wr_addr = 6'h30; wr_data = {27'd0, ph_q};  end
      3'd2:    begin wr_addr = 6'h04; wr_data = a_q;            end
      3'd3:    begin wr_addr = 6'h08; wr_data = b_q;            end
      3'd4:    begin wr_addr = 6'h0C; wr_data = c_q;            end
      3'd5:    begin wr_addr = 6'h10; wr_data = d_q;            end
      default: begin wr_addr = 6'h00; wr_data = {26'd0, cmd_q}; end
    endcase
  end

  assign rd_addr = 6'h14 + {1'b0, ridx_q, 2'b00};

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    widx_d      = widx_q;
    ridx_d      = ridx_q;
    cnt_d       = cnt_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_idx_d   = res_idx_q;
    res_last_d  = res_last_q;
    res_err_d   = res_err_q;
    accept      = 1'b0;
    psel        = 1'b0;
    penable     = 1'b0;
    pwrite      = 1'b0;
    paddr       = 6'h00;
    pwdata      = 32'h0;
    case (state_q)
      S_IDLE: begin
        if (bus.job_valid && job_ready_q) begin
          accept  = 1'b1;
          state_d = S_WR;
          phase_d = 1'b0;
          widx_d  = 3'd0;
        end
      end
      S_WR: begin
        psel    = 1'b1;
        penable = phase_q;
        pwrite  = 1'b1;
        paddr   = wr_addr;
        pwdata  = wr_data;
        phase_d = ~phase_q;
        if (phase_q) begin
          if (widx_q == 3'd6) begin
            state_d = S_WAIT_INT;
            cnt_d   = 8'd0;
          end else begin
            widx_d = widx_q + 3'd1;
          end
        end
      end
      S_WAIT_INT: begin
        if (bus.INT) begin
          ridx_d  = 3'd0;
          phase_d = 1'b0;
          state_d = (nout_q == 3'd0) ? S_CLR : S_RD;
        end else if (cnt_q == TO_LAST) begin
          state_d     = S_RES;
          res_valid_d = 1'b1;
          res_data_d  = 32'h0;
          res_idx_d   = 3'd0;
          res_last_d  = 1'b1;
          res_err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_RD: begin
        psel    = 1'b1;
        penable = phase_q;
        paddr   = rd_addr;
        phase_d = ~phase_q;
        if (phase_q) begin
          state_d     = S_RES;
          res_valid_d = 1'b1;
          res_data_d  = bus.PRDATA;
          res_idx_d   = ridx_q;
          res_last_d  = (ridx_q == nout_q - 3'd1);
          res_err_d   = 1'b0;
        end
      end
      S_RES: begin
        if (bus.res_ready) begin
          res_valid_d = 1'b0;
          phase_d     = 1'b0;
          if (res_last_q) begin
            state_d = S_CLR;
          end else begin
            ridx_d  = ridx_q + 3'd1;
            state_d = S_RD;
          end
        end
      end
      S_CLR: begin
        psel    = 1'b1;
        penable = phase_q;
        pwrite  = 1'b1;
        paddr   = 6'h00;
        pwdata  = 32'h0;
        phase_d = ~phase_q;
        if (phase_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    job_ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      state_q     <= S_IDLE;
      phase_q     <= 1'b0;
      widx_q      <= 3'd0;
      ridx_q      <= 3'd0;
      cnt_q       <= 8'd0;
      job_ready_q <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= 32'h0;
      res_idx_q   <= 3'd0;
      res_last_q  <= 1'b0;
      res_err_q   <= 1'b0;
      cmd_q       <= 6'd0;
      xy_q        <= 5'd0;
      ph_q        <= 5'd0;
      a_q         <= 32'h0;
      b_q         <= 32'h0;
      c_q         <= 32'h0;
      d_q         <= 32'h0;
      nout_q      <= 3'd0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      widx_q      <= widx_d;
      ridx_q      <= ridx_d;
      cnt_q       <= cnt_d;
      job_ready_q <= job_ready_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_idx_q   <= res_idx_d;
      res_last_q  <= res_last_d;
      res_err_q   <= res_err_d;
      if (accept) begin
        cmd_q  <= bus.job_cmd;
        xy_q   <= bus.job_xyfrac;
        ph_q   <= bus.job_phfrac;
        a_q    <= bus.job_a;
        b_q    <= bus.job_b;
        c_q    <= bus.job_c;
        d_q    <= bus.job_d;
        nout_q <= (bus.job_nout > 3'd6) ? 3'd6 : bus.job_nout;
      end
    end
  end

  assign bus.job_ready = job_ready_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = res_data_q;
  assign bus.res_idx   = res_idx_q;
  assign bus.res_last  = res_last_q;
  assign bus.res_err   = res_err_q;
  assign bus.PSEL      = psel;
  assign bus.PENABLE   = penable;
  assign bus.PWRITE    = pwrite;
  assign bus.PADDR     = paddr;
  assign bus.PWDATA    = pwdata;
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_cordic_apb_sequencer.sv
// Bench for cordic_apb_sequencer: a peripheral model answers the APB bus, and a job-level model
// predicts the transfer list, result beats and cycle timing of every job.
module tb_cordic_apb_sequencer;
  localparam int TO_MAIN  = 255;
  localparam int TO_SHORT = 16;

  // ---------------- clock / reset ----------------
  logic PCLK = 1'b0;
  logic PRESETn = 1'b0;
  always #5 PCLK = ~PCLK;

  // ---------------- DUTs and stimulus wiring ----------------
  cordic_apb_sequencer_if bus();
  cordic_apb_sequencer_if bus_to();
  logic [2:0] dbg_state, dbg_state_to;

  cordic_apb_sequencer #(.TIMEOUT_CYCLES(TO_MAIN)) u_dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .bus(bus.master), .dbg_state_o(dbg_state));
  cordic_apb_sequencer #(.TIMEOUT_CYCLES(TO_SHORT)) u_dut_to (
    .PCLK(PCLK), .PRESETn(PRESETn), .bus(bus_to.master), .dbg_state_o(dbg_state_to));

  logic        sel_to = 1'b0;
  logic        tb_job_valid = 1'b0;
  logic [5:0]  tb_cmd = '0;
  logic [4:0]  tb_xy = '0, tb_ph = '0;
  logic [31:0] tb_a = '0, tb_b = '0, tb_c = '0, tb_d = '0;
  logic [2:0]  tb_nout = '0;
  logic        tb_res_ready = 1'b0;
  logic [31:0] tb_prdata = '0;
  logic        tb_int = 1'b0;

  assign bus.job_valid    = tb_job_valid && !sel_to;
  assign bus_to.job_valid = tb_job_valid && sel_to;
  assign bus.job_cmd = tb_cmd;       assign bus_to.job_cmd = tb_cmd;
  assign bus.job_xyfrac = tb_xy;     assign bus_to.job_xyfrac = tb_xy;
  assign bus.job_phfrac = tb_ph;     assign bus_to.job_phfrac = tb_ph;
  assign bus.job_a = tb_a;           assign bus_to.job_a = tb_a;
  assign bus.job_b = tb_b;           assign bus_to.job_b = tb_b;
  assign bus.job_c = tb_c;           assign bus_to.job_c = tb_c;
  assign bus.job_d = tb_d;           assign bus_to.job_d = tb_d;
  assign bus.job_nout = tb_nout;     assign bus_to.job_nout = tb_nout;
  assign bus.res_ready = tb_res_ready; assign bus_to.res_ready = tb_res_ready;
  assign bus.PRDATA = tb_prdata;     assign bus_to.PRDATA = tb_prdata;
  assign bus.INT = tb_int;           assign bus_to.INT = tb_int;

  logic        m_psel, m_penable, m_pwrite, m_job_ready, m_res_valid, m_last, m_err;
  logic [5:0]  m_paddr;
  logic [31:0] m_pwdata, m_data;
  logic [2:0]  m_idx, m_dbg;
  assign m_psel      = sel_to ? bus_to.PSEL      : bus.PSEL;
  assign m_penable   = sel_to ? bus_to.PENABLE   : bus.PENABLE;
  assign m_pwrite    = sel_to ? bus_to.PWRITE    : bus.PWRITE;
  assign m_paddr     = sel_to ? bus_to.PADDR     : bus.PADDR;
  assign m_pwdata    = sel_to ? bus_to.PWDATA    : bus.PWDATA;
  assign m_job_ready = sel_to ? bus_to.job_ready : bus.job_ready;
  assign m_res_valid = sel_to ? bus_to.res_valid : bus.res_valid;
  assign m_data      = sel_to ? bus_to.res_data  : bus.res_data;
  assign m_idx       = sel_to ? bus_to.res_idx   : bus.res_idx;
  assign m_last      = sel_to ? bus_to.res_last  : bus.res_last;
  assign m_err       = sel_to ? bus_to.res_err   : bus.res_err;
  assign m_dbg       = sel_to ? dbg_state_to     : dbg_state;

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [38:0] exp_xfer_q[$];   // {pwrite, paddr, pwdata}
  logic [36:0] exp_beat_q[$];   // {err, last, idx, data}
  logic [31:0] out_val[6];
  bit          int_arm = 1'b0;
  int          int_cnt = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic rand_outs();
    for (int k = 0; k < 6; k++) out_val[k] = $urandom;
  endtask

  // Runs one job end to end; int_dly<0 means the peripheral never raises INT.
  task automatic run_job(input logic [5:0] cmd, input logic [4:0] xy, input logic [4:0] ph,
                         input logic [31:0] a, input logic [2:0] nout, input int stall,
                         input int int_dly, input int rst_read, input bit keep_valid);
    int n_eff, c, nxt_acc, beat_at, stall_left, reads_seen, to_cyc, clr_c, wait_n;
    bit int_ok, setup_open, beat_open, done;
    logic [38:0] setup_word, xfer;
    logic [31:0] b, cc, d;
    b = $urandom; cc = $urandom; d = $urandom;
    to_cyc = sel_to ? TO_SHORT : TO_MAIN;
    n_eff = (nout > 3'd6) ? 6 : int'(nout);
    int_ok = (int_dly >= 0) && (int_dly + 1 <= to_cyc);

    exp_xfer_q.delete();
    exp_beat_q.delete();
    exp_xfer_q.push_back({1'b1, 6'h2C, 27'd0, xy});
    exp_xfer_q.push_back({1'b1, 6'h30, 27'd0, ph});
    exp_xfer_q.push_back({1'b1, 6'h04, a});
    exp_xfer_q.push_back({1'b1, 6'h08, b});
    exp_xfer_q.push_back({1'b1, 6'h0C, cc});
    exp_xfer_q.push_back({1'b1, 6'h10, d});
    exp_xfer_q.push_back({1'b1, 6'h00, 26'd0, cmd});
    if (int_ok) begin
      for (int k = 0; k < n_eff; k++) begin
        exp_xfer_q.push_back({1'b0, 6'(8'h14 + 4 * k), 32'h0});
        exp_beat_q.push_back({1'b0, 1'(k == n_eff - 1), 3'(k), out_val[k]});
      end
    end else begin
      exp_beat_q.push_back({1'b1, 1'b1, 3'd0, 32'h0});
    end
    exp_xfer_q.push_back({1'b1, 6'h00, 32'h0});

    tb_cmd = cmd; tb_xy = xy; tb_ph = ph; tb_a = a; tb_b = b; tb_c = cc; tb_d = d;
    tb_nout = nout; tb_job_valid = 1'b1; tb_res_ready = 1'b0;
    wait_n = 0;
    while (!m_job_ready && wait_n < 100) begin
      @(negedge PCLK);
      wait_n++;
    end
    check("job_accept_ready", 64'(m_job_ready), 64'(1));

    @(negedge PCLK);
    c = 1; nxt_acc = 2; beat_at = -1; stall_left = stall; reads_seen = 0; clr_c = -1;
    setup_open = 0; beat_open = 0; done = 0; setup_word = '0;
    while (!done && c < 2000) begin
      if (c == 1 && !keep_valid) tb_job_valid = 1'b0;
      if (c == 3 && keep_valid) tb_a = ~a;
      if (int_arm) begin
        if (int_cnt == 0) begin tb_int = 1'b1; int_arm = 1'b0; end
        else int_cnt--;
      end

      if (m_psel && !m_penable) begin
        check("apb_setup_order", 64'(setup_open), 64'(0));
        setup_open = 1'b1;
        setup_word = {m_pwrite, m_paddr, m_pwdata};
      end else if (m_psel && m_penable) begin
        check("apb_access_after_setup", 64'(setup_open), 64'(1));
        check("apb_stable", 64'({m_pwrite, m_paddr, m_pwdata}), 64'(setup_word));
        setup_open = 1'b0;
        check("xfer_cycle", 64'(c), 64'(nxt_acc));
        check("xfer_expected", 64'(exp_xfer_q.size() > 0), 64'(1));
        if (exp_xfer_q.size() > 0) begin
          xfer = exp_xfer_q.pop_front();
          if (xfer[38]) check("xfer_write", 64'({m_pwrite, m_paddr, m_pwdata}), 64'(xfer));
          else          check("xfer_read", 64'({m_pwrite, m_paddr}), 64'(xfer[38:32]));
        end
        if (m_pwrite && m_paddr == 6'h00 && m_pwdata != 32'h0) begin
          int_arm = (int_dly >= 0);
          int_cnt = int_dly;
          nxt_acc = int_ok ? c + 3 + int_dly : -1;
          beat_at = int_ok ? -1 : c + 1 + to_cyc;
        end else if (m_pwrite && m_paddr == 6'h00) begin
          tb_int = 1'b0;
          clr_c = c;
          nxt_acc = -1;
        end else if (!m_pwrite) begin
          reads_seen++;
          beat_at = c + 1;
          nxt_acc = -1;
        end else begin
          nxt_acc = c + 2;
        end
      end else begin
        check("apb_idle", 64'({setup_open, m_penable}), 64'(0));
      end

      if (rst_read > 0 && reads_seen == rst_read) begin
        PRESETn = 1'b0;
        tb_res_ready = 1'b0;
        @(negedge PCLK);
        check("rst_apb_zero", 64'({m_psel, m_penable, m_pwrite, m_paddr, m_pwdata}), 64'(0));
        check("rst_res_zero", 64'({m_res_valid, m_last, m_err, m_idx, m_data}), 64'(0));
        check("rst_job_ready_low", 64'(m_job_ready), 64'(0));
        check("rst_idle_state", 64'(m_dbg), 64'(0));
        PRESETn = 1'b1;
        tb_int = 1'b0;
        int_arm = 1'b0;
        exp_xfer_q.delete();
        exp_beat_q.delete();
        @(negedge PCLK);
        check("rst_job_ready_high", 64'(m_job_ready), 64'(1));
        for (int i = 0; i < 4; i++) begin
          @(negedge PCLK);
          check("rst_no_more_activity", 64'({m_res_valid, m_psel}), 64'(0));
        end
        return;
      end

      if (m_res_valid) begin
        check("beat_expected", 64'(exp_beat_q.size() > 0), 64'(1));
        if (exp_beat_q.size() > 0) begin
          if (!beat_open) begin
            check("beat_cycle", 64'(c), 64'(beat_at));
            beat_open = 1'b1;
            stall_left = stall;
          end
          check("beat_word", 64'({m_err, m_last, m_idx, m_data}), 64'(exp_beat_q[0]));
          if (stall_left > 0) begin
            tb_res_ready = 1'b0;
            stall_left--;
          end else begin
            tb_res_ready = 1'b1;
            void'(exp_beat_q.pop_front());
            beat_open = 1'b0;
            beat_at = -1;
            nxt_acc = c + 2;
          end
        end
      end else begin
        tb_res_ready = 1'b0;
      end

      if (m_psel && !m_pwrite && m_paddr >= 6'h14 && m_paddr <= 6'h28)
        tb_prdata = out_val[int'(m_paddr - 6'h14) / 4];
      else
        tb_prdata = $urandom;

      if (m_job_ready) begin
        check("job_end_cycle", 64'(c), 64'(clr_c + 1));
        check("xfers_left", 64'(exp_xfer_q.size()), 64'(0));
        check("beats_left", 64'(exp_beat_q.size()), 64'(0));
        done = 1'b1;
      end else begin
        @(negedge PCLK);
        c++;
      end
    end
    check("job_completed", 64'(done), 64'(1));
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [5:0] cmds[3];
    cmds[0] = 6'h01; cmds[1] = 6'h03; cmds[2] = 6'h07;

    PRESETn = 1'b0;
    repeat (3) @(negedge PCLK);
    check("reset_job_ready", 64'({bus.job_ready, bus_to.job_ready}), 64'(0));
    check("reset_apb", 64'({bus.PSEL, bus.PENABLE, bus.PWRITE, bus.PADDR, bus.PWDATA}), 64'(0));
    check("reset_res", 64'({bus.res_valid, bus.res_last, bus.res_err, bus.res_idx, bus.res_data}), 64'(0));
    check("reset_state", 64'({dbg_state, dbg_state_to}), 64'(0));
    PRESETn = 1'b1;
    @(negedge PCLK);
    check("ready_after_reset", 64'({bus.job_ready, bus_to.job_ready}), 64'(2'b11));

    // INVTAN job, one OUT register, INT 20 cycles after start
    rand_outs();
    out_val[0] = 32'h0C90FDAA;
    run_job(6'h03, 5'h10, 5'h1C, 32'h00010000, 3'd1, 0, 20, 0, 1'b0);

    // SVD, six beats, consumer stalls 3 cycles per beat
    rand_outs();
    run_job(6'h07, 5'($urandom), 5'($urandom), $urandom, 3'd6, 3, $urandom_range(0, 30), 0, 1'b0);

    // INT never arrives on the short-timeout instance
    sel_to = 1'b1;
    rand_outs();
    run_job(6'h01, 5'($urandom), 5'($urandom), $urandom, 3'($urandom_range(1, 6)), 2, -1, 0, 1'b0);
    sel_to = 1'b0;

    // nout edge values, INT already present on WAIT_INT entry for the first one
    rand_outs();
    run_job(6'h03, 5'($urandom), 5'($urandom), $urandom, 3'd0, 0, 0, 0, 1'b0);
    rand_outs();
    run_job(6'h01, 5'($urandom), 5'($urandom), $urandom, 3'd7, 1, 0, 0, 1'b0);

    // reset during the second read's ACCESS
    rand_outs();
    run_job(6'h07, 5'($urandom), 5'($urandom), $urandom, 3'd4, 0, 5, 2, 1'b0);

    // job_valid held high across two jobs, job_a changes mid-job
    rand_outs();
    run_job(6'h03, 5'($urandom), 5'($urandom), $urandom, 3'd2, 1, 3, 0, 1'b1);
    rand_outs();
    run_job(6'h01, 5'($urandom), 5'($urandom), $urandom, 3'd1, 0, 4, 0, 1'b0);

    // full-length timeout on the default instance
    rand_outs();
    run_job(6'h07, 5'($urandom), 5'($urandom), $urandom, 3'd3, 0, -1, 0, 1'b0);

    for (int j = 0; j < 6; j++) begin
      rand_outs();
      run_job(cmds[$urandom_range(0, 2)], 5'($urandom), 5'($urandom), $urandom,
              3'($urandom_range(0, 7)), $urandom_range(0, 4), $urandom_range(0, 30), 0, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
